// File: rtl/hazard_unit_pkg.sv
// Shared types for the decode-stage hazard unit: RV32 opcodes, register and forwarding types,
// slot record and the per-source forwarding resolver.
package opcodes;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
endpackage

package rv32;
  typedef logic [31:0] inst_t;
  typedef logic [4:0]  addr_t;

  typedef enum logic [1:0] {
    RS_REG = 2'd0,
    RS_ALU = 2'd1,
    RS_EXE = 2'd2,
    RS_MEM = 2'd3
  } rs_t;

  typedef struct packed {
    logic  valid;
    addr_t rd;
    logic  load;
  } hazard_slot_t;
endpackage

package hazard_unit_pkg;
  import rv32::*;

  localparam int    DEPTH    = 3;
  localparam addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic lock;
    rs_t  sel;
  } fwd_t;

  function automatic logic slot_hit(hazard_slot_t s, addr_t a);
    return s.valid && (s.rd == a);
  endfunction

  // Youngest producer wins; a load still in execute or memory cannot be forwarded yet.
  function automatic fwd_t resolve(logic used, addr_t a,
                                   hazard_slot_t s0, hazard_slot_t s1, hazard_slot_t s2);
    fwd_t f;
    f.lock = 1'b0;
    f.sel  = RS_REG;
    if (used && (a != REG_ZERO)) begin
      if (slot_hit(s0, a)) begin
        if (s0.load) f.lock = 1'b1;
        else         f.sel  = RS_ALU;
      end else if (slot_hit(s1, a)) begin
        if (s1.load) f.lock = 1'b1;
        else         f.sel  = RS_EXE;
      end else if (slot_hit(s2, a)) begin
        f.sel = RS_MEM;
      end
    end
    return f;
  endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// Decode-side handshake and forwarding-control bundle for hazard_unit.
// Optional HAZARD_STATS_EN adds the stall/forward counters.
interface hazard_unit_if;
  import rv32::*;

  inst_t id_ir;
  logic  id_valid;
  logic  id_fire;
  logic  advance;
  logic  flush;
  rs_t   rs1_sel;
  rs_t   rs2_sel;
  logic  lock;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
  logic [31:0] forward_count;
`endif

  modport master (
    output id_ir, id_valid, id_fire, advance, flush,
`ifdef HAZARD_STATS_EN
    input  stall_count, forward_count,
`endif
    input  rs1_sel, rs2_sel, lock
  );

  modport slave (
    input  id_ir, id_valid, id_fire, advance, flush,
`ifdef HAZARD_STATS_EN
    output stall_count, forward_count,
`endif
    output rs1_sel, rs2_sel, lock
  );
endinterface

// File: rtl/hazard_unit_inst_regs.sv
// Purpose: combinational register-usage decoder for one RV32 instruction.
// Latency: zero. Backpressure: none (pure function of the instruction word).
module inst_regs
  import rv32::*;
  import opcodes::*;
  import hazard_unit_pkg::*;
(
  input  inst_t ir,
  output addr_t rs1,
  output addr_t rs2,
  output addr_t rd,
  output logic  rs1_used,
  output logic  rs2_used,
  output logic  writes_rd,
  output logic  is_load
);
  logic wr_op;
  logic unused_funct;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];
  assign unused_funct = ^{ir[31:25], ir[14:12]};

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    wr_op    = 1'b0;
    is_load  = 1'b0;
    case (ir[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: wr_op = 1'b1;
      OP_JALR, OP_IMM: begin
        rs1_used = 1'b1;
        wr_op    = 1'b1;
      end
      OP_LOAD: begin
        rs1_used = 1'b1;
        wr_op    = 1'b1;
        is_load  = 1'b1;
      end
      OP_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        wr_op    = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: ;
    endcase
  end

  // x0 writes are architecturally discarded, so they never become producers.
  assign writes_rd = wr_op && (rd != REG_ZERO);
endmodule

// File: rtl/hazard_unit.sv
// Purpose: tracks execute/memory/writeback destinations; drives rs1/rs2 forwarding selects and decode lock.
// Latency: selects and lock are same-cycle combinational; slot state updates one cycle later on advance.
// Backpressure: lock gates decode; slots hold while advance=0. Macro HAZARD_STATS_EN adds counters.
module hazard_unit
  import rv32::*;
  import hazard_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  hazard_unit_if.slave bus
);
  hazard_slot_t slots [DEPTH];

  addr_t rs1_addr, rs2_addr, rd_addr;
  logic  rs1_used, rs2_used, writes_rd, is_load;
  fwd_t  f1, f2;

  inst_regs u_dec (
    .ir        (bus.id_ir),
    .rs1       (rs1_addr),
    .rs2       (rs2_addr),
    .rd        (rd_addr),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .writes_rd (writes_rd),
    .is_load   (is_load)
  );

  assign f1 = resolve(rs1_used, rs1_addr, slots[0], slots[1], slots[2]);
  assign f2 = resolve(rs2_used, rs2_addr, slots[0], slots[1], slots[2]);

  assign bus.rs1_sel = f1.sel;
  assign bus.rs2_sel = f2.sel;
  assign bus.lock    = bus.id_valid & (f1.lock | f2.lock);

  // A flushed or stalled decode slot enters execute as a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (bus.advance) begin
      for (int i = DEPTH - 1; i > 0; i--) slots[i] <= slots[i-1];
      slots[0].valid <= bus.id_fire & writes_rd & ~bus.flush;
      slots[0].rd    <= rd_addr;
      slots[0].load  <= is_load;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.stall_count   <= '0;
      bus.forward_count <= '0;
    end else begin
      if (bus.lock && bus.advance)
        bus.stall_count <= bus.stall_count + 32'd1;
      if (bus.id_fire && ((f1.sel != RS_REG) || (f2.sel != RS_REG)))
        bus.forward_count <= bus.forward_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: stimulus pushes expected {lock, rs1_sel, rs2_sel}
// per cycle into a queue; a negedge monitor pops and compares.
module tb_hazard_unit;
  import rv32::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [4:0] exp_q[$];
  string      name_q[$];

  hazard_unit_if bus();

  hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ex(logic l, rs_t r1, rs_t r2);
    return {l, r1, r2};
  endfunction

  function automatic inst_t addi(addr_t rd, addr_t rs1, logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic inst_t add(addr_t rd, addr_t rs1, addr_t rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic inst_t lw(addr_t rd, addr_t rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic inst_t sw(addr_t rs2, addr_t rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic inst_t lui(addr_t rd, logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic step(input inst_t ir, input logic vld, input logic fire, input logic adv,
                      input logic fl, input logic rst, input logic [4:0] e, input string nm);
    @(posedge clk);
    #1;
    bus.id_ir    = ir;
    bus.id_valid = vld;
    bus.id_fire  = fire;
    bus.advance  = adv;
    bus.flush    = fl;
    reset        = rst;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Issue one instruction that fires (valid, fire, advance).
  task automatic issue(input inst_t ir, input logic [4:0] e, input string nm);
    step(ir, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, e, nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      logic [4:0] got;
      string nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {bus.lock, bus.rs1_sel, bus.rs2_sel};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got lock=%0d rs1=%0d rs2=%0d, want lock=%0d rs1=%0d rs2=%0d",
                 nm, got[4], got[3:2], got[1:0], e[4], e[3:2], e[1:0]);
      end
    end
  end

  localparam rs_t R = RS_REG;
  localparam rs_t A = RS_ALU;
  localparam rs_t E = RS_EXE;
  localparam rs_t M = RS_MEM;

  initial begin
    inst_t nop;
    nop = addi(5'd0, 5'd0, 12'd0);
    bus.id_ir = '0; bus.id_valid = 1'b0; bus.id_fire = 1'b0;
    bus.advance = 1'b0; bus.flush = 1'b0;

    step(add(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ex(0, R, R), "reset_a");
    step(add(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(0, R, R), "reset_b");
`ifdef HAZARD_STATS_EN
    @(negedge clk);
    checks++;
    if (bus.stall_count !== 32'd0) begin
      failures++;
      $display("FAIL stall_count_reset: got %0d want 0", bus.stall_count);
    end
`endif

    // Back-to-back ALU dependency
    issue(addi(5'd5, 5'd0, 12'd1), ex(0, R, R), "alu_prod");
    issue(add(5'd6, 5'd5, 5'd5),   ex(0, A, A), "alu_use");

    // Distance 2, 3, 4 producers
    issue(addi(5'd7, 5'd0, 12'd1), ex(0, R, R), "d2_prod");
    issue(nop,                     ex(0, R, R), "d2_nop");
    issue(add(5'd8, 5'd7, 5'd0),   ex(0, E, R), "d2_use");
    issue(addi(5'd7, 5'd0, 12'd1), ex(0, R, R), "d3_prod");
    issue(nop,                     ex(0, R, R), "d3_nop1");
    issue(nop,                     ex(0, R, R), "d3_nop2");
    issue(add(5'd8, 5'd7, 5'd0),   ex(0, M, R), "d3_use");
    issue(addi(5'd7, 5'd0, 12'd1), ex(0, R, R), "d4_prod");
    for (int i = 0; i < 3; i++) issue(nop, ex(0, R, R), "d4_nop");
    issue(add(5'd8, 5'd7, 5'd0),   ex(0, R, R), "d4_use");

    // Load-use immediately behind: two lock cycles then MEM
    issue(lw(5'd9, 5'd1), ex(0, R, R), "lu_load");
    step(add(5'd10, 5'd9, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(1, R, R), "lu_lock1");
    step(add(5'd10, 5'd9, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(1, R, R), "lu_lock2");
    issue(add(5'd10, 5'd9, 5'd0), ex(0, M, R), "lu_mem");

    // Consumer one instruction behind a load: one lock cycle
    issue(lw(5'd13, 5'd0), ex(0, R, R), "lu1_load");
    issue(nop,             ex(0, R, R), "lu1_nop");
    step(add(5'd14, 5'd13, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(1, R, R), "lu1_lock");
    issue(add(5'd14, 5'd13, 5'd0), ex(0, M, R), "lu1_mem");

    // x0 destinations and unused sources
    issue(addi(5'd0, 5'd0, 12'd5), ex(0, R, R), "x0_write");
    issue(sw(5'd0, 5'd0),          ex(0, R, R), "x0_store");
    issue(lui(5'd3, 20'h1),        ex(0, R, R), "lui_a");
    issue(lui(5'd3, 20'h2),        ex(0, R, R), "lui_b");

    // Store data (rs2) depending on a load
    issue(lw(5'd4, 5'd0), ex(0, R, R), "st_load");
    step(sw(5'd4, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(1, R, R), "st_lock1");
    step(sw(5'd4, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(1, R, R), "st_lock2");
    issue(sw(5'd4, 5'd0), ex(0, R, M), "st_mem");

    // Flushed producer leaves no trace
    step(addi(5'd11, 5'd0, 12'd1), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ex(0, R, R), "fl_prod");
    issue(add(5'd12, 5'd11, 5'd0), ex(0, R, R), "fl_use");

    // Hold advance low in the middle of a load-use stall
    issue(lw(5'd15, 5'd0), ex(0, R, R), "hold_load");
    step(add(5'd16, 5'd15, 5'd15), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(1, R, R), "hold_lock1");
    for (int i = 0; i < 4; i++)
      step(add(5'd16, 5'd15, 5'd15), 1'b1, 1'b0, 1'b0, (i == 1), 1'b0, ex(1, R, R), "hold_frozen");
    step(add(5'd16, 5'd15, 5'd15), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(1, R, R), "hold_lock2");
    issue(add(5'd16, 5'd15, 5'd15), ex(0, M, M), "hold_mem");

    // Reset in the middle of a stall
    issue(lw(5'd17, 5'd0), ex(0, R, R), "rs_load");
    step(add(5'd18, 5'd17, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(1, R, R), "rs_lock");
    step(add(5'd18, 5'd17, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ex(1, R, R), "rs_in_reset");
    step(add(5'd18, 5'd17, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ex(0, R, R), "rs_after");
`ifdef HAZARD_STATS_EN
    @(negedge clk);
    checks++;
    if (bus.stall_count !== 32'd0) begin
      failures++;
      $display("FAIL stall_count_midreset: got %0d want 0", bus.stall_count);
    end
`endif
    issue(add(5'd18, 5'd17, 5'd0), ex(0, R, R), "rs_fire");

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
